// File: rtl/tri_bus_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tri_bus_receiver
//  Purpose  : Listener side of a shared tri-state bus segment. Waits one
//             settle cycle after the driver's strobe, samples the bus,
//             acknowledges over a four-phase handshake and queues the word
//             in a show-ahead FIFO for the local consumer.
//  Options  : TRI_BUS_FLOAT_CHECK_EN - reject words containing X/Z bits
//             (simulation-only 4-state check) and raise float_err.
//  Revision : 1.0 - initial release
// ============================================================================
module tri_bus_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         bus_data,
  input  logic                     bus_strobe,
  output logic                     bus_ack,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_flags,
  output logic                     float_err
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SETTLE  = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_ACK     = 2'b11
  } state_t;

  state_t                r_state;
  logic                  r_ack;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_cap_try;
  logic                  w_cap_go;
  logic                  w_stall;
  logic                  w_float;
  logic                  w_write;
  logic                  w_pop;

  assign w_full    = (r_count == c_full_count);
  assign w_empty   = (r_count == '0);
  // A capture attempt is any CAPTURE cycle where the driver still holds strobe.
  assign w_cap_try = (r_state == ST_CAPTURE) && bus_strobe;
  // Full blocks the handshake even if a pop frees a slot this same cycle.
  assign w_cap_go  = w_cap_try && !w_full;
  assign w_stall   = w_cap_try && w_full;

`ifdef TRI_BUS_FLOAT_CHECK_EN
  // Reduction XOR yields X whenever any bit is X or Z.
  assign w_float = ((^bus_data) === 1'bx);
`else
  assign w_float = 1'b0;
`endif

  assign w_write = w_cap_go && !w_float;
  assign w_pop   = rd_en && !w_empty;

  // Handshake sequencer: strobe -> settle -> capture -> ack until strobe drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus_strobe) r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_state <= bus_strobe ? ST_CAPTURE : ST_IDLE;
        end
        ST_CAPTURE: begin
          if (!bus_strobe) begin
            r_state <= ST_IDLE;
          end else if (!w_full) begin
            r_ack   <= 1'b1;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!bus_strobe) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= bus_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky stall flag; a new stall in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_stall) begin
      r_overflow <= 1'b1;
    end else if (clr_flags) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef TRI_BUS_FLOAT_CHECK_EN
  logic r_float_err;

  // Sticky float flag; a new float in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_float_err <= 1'b0;
    end else if (w_cap_go && w_float) begin
      r_float_err <= 1'b1;
    end else if (clr_flags) begin
      r_float_err <= 1'b0;
    end
  end

  assign float_err = r_float_err;
`else
  assign float_err = 1'b0;
`endif

  assign bus_ack  = r_ack;
  assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tri_bus_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tri_bus_receiver
//  Purpose  : Self-checking bench for tri_bus_receiver. Captured words are
//             queued in a scoreboard and compared as the consumer pops them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tri_bus_receiver;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_data;
  logic       bus_strobe;
  logic       bus_ack;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       clr_flags;
  logic       float_err;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] sb [$];

  tri_bus_receiver #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_data   (bus_data),
    .bus_strobe (bus_strobe),
    .bus_ack    (bus_ack),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .clr_flags  (clr_flags),
    .float_err  (float_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise strobe at a negedge and wait (bounded) for ack; cycles = posedges seen.
  task automatic start_xfer(input logic [7:0] d, output bit got, output int cycles);
    bus_data   = d;
    bus_strobe = 1'b1;
    got    = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if (bus_ack) begin
        got = 1'b1;
        sb.push_back(d);
        break;
      end
    end
  endtask

  // Drop strobe and wait (bounded) for ack to fall.
  task automatic finish_xfer(output bit got);
    bus_strobe = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus_ack) begin
        got = 1'b1;
        break;
      end
    end
    bus_data = 8'h00;
  endtask

  // Pop one word; returns the head as seen before the pop edge.
  task automatic do_pop(output logic [7:0] seen);
    seen  = rd_data;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus_ack !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 ||
                    rd_data !== 8'h00 || overflow !== 1'b0 || float_err !== 1'b0)
      $display("FAIL reset_values ack=%b empty=%b full=%b count=%0d rd=%h ovf=%b ferr=%b",
               bus_ack, empty, full, count, rd_data, overflow, float_err);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit got, got2; int cyc; logic [7:0] seen, exp;
    start_xfer(8'hA5, got, cyc);
    n_checks++; if (!got || cyc !== 3)
      $display("FAIL single_latency got_ack=%b cycles=%0d expected 3", got, cyc);
    else n_pass++;
    n_checks++; if (empty !== 1'b0 || count !== 3'd1 || rd_data !== 8'hA5)
      $display("FAIL single_state empty=%b count=%0d rd=%h expected 0/1/a5", empty, count, rd_data);
    else n_pass++;
    finish_xfer(got2);
    n_checks++; if (!got2) $display("FAIL single_ack_drop ack=%b expected 0", bus_ack); else n_pass++;
    do_pop(seen);
    exp = sb.pop_front();
    n_checks++; if (seen !== exp) $display("FAIL single_pop got %h expected %h", seen, exp); else n_pass++;
    n_checks++; if (empty !== 1'b1 || rd_data !== 8'h00)
      $display("FAIL single_empty empty=%b rd=%h expected 1/00", empty, rd_data);
    else n_pass++;
  endtask

  task automatic test_fill_stall();
    bit got, got2; int cyc; logic [7:0] seen, exp;
    for (int i = 1; i <= 4; i++) begin
      start_xfer(8'(i), got, cyc);
      finish_xfer(got2);
      n_checks++; if (!got || !got2) $display("FAIL fill_xfer%0d ack_rise=%b ack_fall=%b expected 1/1", i, got, got2);
      else n_pass++;
    end
    n_checks++; if (full !== 1'b1 || count !== 3'd4)
      $display("FAIL fill_full full=%b count=%0d expected 1/4", full, count);
    else n_pass++;
    bus_data   = 8'h05;
    bus_strobe = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (bus_ack !== 1'b0 || overflow !== 1'b1)
      $display("FAIL stall ack=%b overflow=%b expected 0/1", bus_ack, overflow);
    else n_pass++;
    do_pop(seen);
    exp = sb.pop_front();
    n_checks++; if (seen !== exp) $display("FAIL stall_pop got %h expected %h", seen, exp); else n_pass++;
    n_checks++; if (count !== 3'd3 || bus_ack !== 1'b0)
      $display("FAIL stall_blocked count=%0d ack=%b expected 3/0", count, bus_ack);
    else n_pass++;
    start_xfer(8'h05, got, cyc);
    n_checks++; if (!got || cyc !== 1)
      $display("FAIL stall_resume got_ack=%b cycles=%0d expected 1", got, cyc);
    else n_pass++;
    finish_xfer(got2);
    for (int i = 0; i < 4; i++) begin
      do_pop(seen);
      exp = sb.pop_front();
      n_checks++; if (seen !== exp) $display("FAIL wrap_pop%0d got %h expected %h", i, seen, exp); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b expected 1", overflow); else n_pass++;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    n_checks++; if (overflow !== 1'b0 || empty !== 1'b1)
      $display("FAIL ovf_clear overflow=%b empty=%b expected 0/1", overflow, empty);
    else n_pass++;
  endtask

  task automatic test_abort();
    bit saw_ack, got, got2; int cyc; logic [7:0] seen, exp;
    saw_ack    = 1'b0;
    bus_data   = 8'h77;
    bus_strobe = 1'b1;
    @(negedge clk);
    bus_strobe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_ack) saw_ack = 1'b1;
    end
    n_checks++; if (saw_ack || count !== 3'd0)
      $display("FAIL abort saw_ack=%b count=%0d expected 0/0", saw_ack, count);
    else n_pass++;
    start_xfer(8'h5A, got, cyc);
    n_checks++; if (!got || cyc !== 3)
      $display("FAIL abort_recover got_ack=%b cycles=%0d expected 3", got, cyc);
    else n_pass++;
    finish_xfer(got2);
    do_pop(seen);
    exp = sb.pop_front();
    n_checks++; if (seen !== exp) $display("FAIL abort_pop got %h expected %h", seen, exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit got, got2; int cyc; logic [7:0] seen, exp;
    start_xfer(8'h11, got, cyc); finish_xfer(got2);
    start_xfer(8'h22, got, cyc); finish_xfer(got2);
    n_checks++; if (count !== 3'd2) $display("FAIL pp_setup count=%0d expected 2", count); else n_pass++;
    bus_data   = 8'h33;
    bus_strobe = 1'b1;
    repeat (2) @(negedge clk);
    seen  = rd_data;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    exp = sb.pop_front();
    sb.push_back(8'h33);
    n_checks++; if (seen !== exp) $display("FAIL pp_head_before got %h expected %h", seen, exp); else n_pass++;
    n_checks++; if (count !== 3'd2 || bus_ack !== 1'b1 || rd_data !== sb[0])
      $display("FAIL pp_same_cycle count=%0d ack=%b rd=%h expected 2/1/%h", count, bus_ack, rd_data, sb[0]);
    else n_pass++;
    finish_xfer(got2);
    for (int i = 0; i < 2; i++) begin
      do_pop(seen);
      exp = sb.pop_front();
      n_checks++; if (seen !== exp) $display("FAIL pp_drain%0d got %h expected %h", i, seen, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit got, got2; int cyc; logic [7:0] seen, exp;
    start_xfer(8'h99, got, cyc);
    rst_n = 1'b0;
    #1;
    n_checks++; if (!got || bus_ack !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 ||
                    rd_data !== 8'h00 || overflow !== 1'b0)
      $display("FAIL reset_mid got_ack=%b ack=%b count=%0d empty=%b full=%b rd=%h ovf=%b", got,
               bus_ack, count, empty, full, rd_data, overflow);
    else n_pass++;
    sb.delete();
    bus_strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_xfer(8'h3C, got, cyc);
    n_checks++; if (!got || cyc !== 3 || count !== 3'd1)
      $display("FAIL reset_retry got_ack=%b cycles=%0d count=%0d expected 3/1", got, cyc, count);
    else n_pass++;
    finish_xfer(got2);
    do_pop(seen);
    exp = sb.pop_front();
    n_checks++; if (seen !== exp) $display("FAIL reset_retry_pop got %h expected %h", seen, exp); else n_pass++;
  endtask

  task automatic test_float();
    bit got, got2; int cyc; logic [7:0] seen;
    start_xfer(8'hzz, got, cyc);
    finish_xfer(got2);
    n_checks++; if (!got || !got2) $display("FAIL float_handshake rise=%b fall=%b expected 1/1", got, got2);
    else n_pass++;
`ifdef TRI_BUS_FLOAT_CHECK_EN
    void'(sb.pop_back());
    n_checks++; if (count !== 3'd0 || float_err !== 1'b1)
      $display("FAIL float_reject count=%0d float_err=%b expected 0/1", count, float_err);
    else n_pass++;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    n_checks++; if (float_err !== 1'b0) $display("FAIL float_clear got %b expected 0", float_err); else n_pass++;
`else
    n_checks++; if (count !== 3'd1 || float_err !== 1'b0)
      $display("FAIL float_stored count=%0d float_err=%b expected 1/0", count, float_err);
    else n_pass++;
    do_pop(seen);
    void'(sb.pop_front());
    n_checks++; if (empty !== 1'b1) $display("FAIL float_drain empty=%b expected 1", empty); else n_pass++;
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_data   = 8'h00;
    bus_strobe = 1'b0;
    rd_en      = 1'b0;
    clr_flags  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_float();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
